// File: rtl/mult_acc_pkg.sv
// Shared widths, control sideband and helpers for the pipelined multiplier-accumulator.
package mult_acc_pkg;

  typedef struct packed {
    logic vld;
    logic sgn;
    logic acc_en;
    logic acc_clr;
  } ctl_t;

  function automatic int p_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  function automatic int dout_width(input int wa, input int wb, input int guard);
    return wa + wb + guard;
  endfunction

  function automatic bit params_ok(input int wa, input int wb, input int ps, input int guard);
    return (wa >= 2) && (wa <= 18) && (wb >= 2) && (wb <= 18) &&
           (ps >= 0) && (ps <= 3) && (guard >= 0);
  endfunction

  // Fill bit when widening an operand: copies the MSB only for two's complement beats.
  function automatic logic ext_fill(input logic sgn, input logic msb);
    return sgn & msb;
  endfunction

endpackage

// File: rtl/mult_pipe_core.sv
// Input register, inferred signed product and PIPE_STAGES delay line with control sideband.
module mult_pipe_core
  import mult_acc_pkg::*;
#(
  parameter int WIDTH_A     = 12,
  parameter int WIDTH_B     = 12,
  parameter int PIPE_STAGES = 1,
  localparam int P_W        = p_width(WIDTH_A, WIDTH_B)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ce,
  input  logic               i_valid,
  input  logic [WIDTH_A-1:0] i_a,
  input  logic [WIDTH_B-1:0] i_b,
  input  logic               i_sgn,
  input  logic               i_acc_en,
  input  logic               i_acc_clr,
  output logic [P_W-1:0]     o_prod,
  output ctl_t               o_ctl
);

  logic [WIDTH_A-1:0]      r_a;
  logic [WIDTH_B-1:0]      r_b;
  ctl_t                    r_ctl0;
  logic signed [WIDTH_A:0] w_ea;
  logic signed [WIDTH_B:0] w_eb;
  logic signed [P_W-1:0]   w_prod;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ctl0 <= '0;
    end else if (i_ce) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_ctl0 <= '{vld: i_valid, sgn: i_sgn, acc_en: i_acc_en, acc_clr: i_acc_clr};
    end
  end

  // One extra bit per operand makes unsigned values positive, so a single signed
  // multiply covers both modes; the low P_W bits hold every reachable product.
  assign w_ea   = {ext_fill(r_ctl0.sgn, r_a[WIDTH_A-1]), r_a};
  assign w_eb   = {ext_fill(r_ctl0.sgn, r_b[WIDTH_B-1]), r_b};
  assign w_prod = w_ea * w_eb;

  logic [P_W-1:0] w_prod_chain [0:PIPE_STAGES];
  ctl_t           w_ctl_chain  [0:PIPE_STAGES];

  assign w_prod_chain[0] = w_prod;
  assign w_ctl_chain[0]  = r_ctl0;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    logic [P_W-1:0] r_prod;
    ctl_t           r_ctl;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_prod <= '0;
        r_ctl  <= '0;
      end else if (i_ce) begin
        r_prod <= w_prod_chain[i];
        r_ctl  <= w_ctl_chain[i];
      end
    end

    assign w_prod_chain[i+1] = r_prod;
    assign w_ctl_chain[i+1]  = r_ctl;
  end

  assign o_prod = w_prod_chain[PIPE_STAGES];
  assign o_ctl  = w_ctl_chain[PIPE_STAGES];

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined multiplier-accumulator: product pipe plus the output/accumulator register
// with sticky overflow.
module mult_acc_pipe
  import mult_acc_pkg::*;
#(
  parameter int WIDTH_A     = 12,
  parameter int WIDTH_B     = 12,
  parameter int PIPE_STAGES = 1,
  parameter int ACC_GUARD   = 4,
  localparam int P_W        = p_width(WIDTH_A, WIDTH_B),
  localparam int DOUT_W     = dout_width(WIDTH_A, WIDTH_B, ACC_GUARD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic               signed_mode,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  output logic [DOUT_W-1:0]  dout,
  output logic               ovf
);

  if (!params_ok(WIDTH_A, WIDTH_B, PIPE_STAGES, ACC_GUARD)) begin : g_bad_params
    $error("mult_acc_pipe: parameter out of range");
  end

  logic [P_W-1:0]    w_prod;
  ctl_t              w_ctl;
  logic [DOUT_W-1:0] w_ext;
  logic [DOUT_W:0]   w_sum;
  logic              w_ovf_s;
  logic              w_ovf_u;

  logic              r_vld;
  logic [DOUT_W-1:0] r_dout;
  logic              r_ovf;

  mult_pipe_core #(
    .WIDTH_A    (WIDTH_A),
    .WIDTH_B    (WIDTH_B),
    .PIPE_STAGES(PIPE_STAGES)
  ) u_core (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_ce     (ce),
    .i_valid  (in_valid),
    .i_a      (a),
    .i_b      (b),
    .i_sgn    (signed_mode),
    .i_acc_en (acc_en),
    .i_acc_clr(acc_clr),
    .o_prod   (w_prod),
    .o_ctl    (w_ctl)
  );

  always_comb begin
    w_ext   = w_ctl.sgn ? DOUT_W'($signed(w_prod)) : DOUT_W'(w_prod);
    w_sum   = {1'b0, r_dout} + {1'b0, w_ext};
    // Signed overflow: both addends share a sign that the wrapped sum does not.
    w_ovf_s = (r_dout[DOUT_W-1] == w_ext[DOUT_W-1]) &&
              (w_sum[DOUT_W-1] != r_dout[DOUT_W-1]);
    w_ovf_u = w_sum[DOUT_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (ce) begin
      r_vld <= w_ctl.vld;
      if (w_ctl.vld) begin
        if (!w_ctl.acc_en) begin
          r_dout <= w_ext;
        end else if (w_ctl.acc_clr) begin
          r_dout <= w_ext;
          r_ovf  <= 1'b0;
        end else begin
          r_dout <= w_sum[DOUT_W-1:0];
          if (w_ctl.sgn ? w_ovf_s : w_ovf_u) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_vld;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed bench for mult_acc_pipe (12x12, one extra stage, 28-bit result) with an
// arithmetic reference model checked every cycle.
module tb_mult_acc_pipe;

  localparam int    DW   = 28;
  localparam longint MOD = 64'sd1 << DW;
  localparam longint MSK = MOD - 1;
  localparam int    LAT  = 2;  // enabled edges between input sample and result

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b1;
  logic          in_valid = 1'b0;
  logic [11:0]   a = '0;
  logic [11:0]   b = '0;
  logic          signed_mode = 1'b0;
  logic          acc_en = 1'b0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic [DW-1:0] dout;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mult_acc_pipe #(
    .WIDTH_A(12), .WIDTH_B(12), .PIPE_STAGES(1), .ACC_GUARD(4)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .signed_mode(signed_mode), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: result of each beat computed from the arithmetic rules at input time.
  typedef struct { bit v; longint d; bit o; } exp_t;
  exp_t   q[$];
  longint m_dout = 0;
  bit     m_ovf  = 0;

  function automatic longint sext(input longint x);
    return (x >= (MOD / 2)) ? x - MOD : x;
  endfunction

  task automatic model_beat(input bit v, input logic [11:0] ta, input logic [11:0] tb_,
                            input bit s, input bit ae, input bit ac);
    longint sa, sb, p, sum;
    exp_t e;
    if (v) begin
      sa = s ? longint'($signed(ta)) : longint'(ta);
      sb = s ? longint'($signed(tb_)) : longint'(tb_);
      p  = sa * sb;
      if (!ae || ac) begin
        m_dout = p & MSK;
        if (ae) m_ovf = 0;
      end else begin
        if (s) begin
          sum = sext(m_dout) + p;
          if (sum > (MOD / 2) - 1 || sum < -(MOD / 2)) m_ovf = 1;
        end else begin
          sum = m_dout + p;
          if (sum >= MOD) m_ovf = 1;
        end
        m_dout = sum & MSK;
      end
    end
    e.v = v; e.d = m_dout; e.o = m_ovf;
    q.push_back(e);
  endtask

  always @(posedge clk) begin : p_cmp
    exp_t e;
    if (reset) begin
      q.delete();
      m_dout = 0;
      m_ovf  = 0;
    end else if (ce) begin
      model_beat(in_valid, a, b, signed_mode, acc_en, acc_clr);
    end
    #1;
    if (q.size() > LAT) e = q[q.size() - 1 - LAT];
    else begin e.v = 0; e.d = 0; e.o = 0; end
    chk("model_valid", 64'(out_valid), 64'(e.v));
    chk("model_dout",  64'(dout),      64'(e.d));
    chk("model_ovf",   64'(ovf),       64'(e.o));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [11:0] ta, input logic [11:0] tb_,
                       input bit s, input bit ae, input bit ac);
    in_valid = v; a = ta; b = tb_; signed_mode = s; acc_en = ae; acc_clr = ac;
  endtask

  task automatic idle();
    drive(0, 12'd0, 12'd0, 0, 0, 0);
  endtask

  task automatic expect_out(input string name, input bit v, input longint d, input bit o);
    chk({name, "_valid"}, 64'(out_valid), 64'(v));
    chk({name, "_dout"},  64'(dout),      64'(d));
    chk({name, "_ovf"},   64'(ovf),       64'(o));
  endtask

  initial begin
    repeat (2) tick();
    expect_out("reset", 0, 0, 0);
    reset = 1'b0;
    tick();

    // Unsigned full-scale product, exact latency
    drive(1, 12'd4095, 12'd4095, 0, 0, 0); tick();
    chk("lat_c1", 64'(out_valid), 64'd0);
    idle(); tick();
    chk("lat_c2", 64'(out_valid), 64'd0);
    tick();
    expect_out("umax", 1, 16769025, 0);
    tick();
    chk("umax_single", 64'(out_valid), 64'd0);

    // Signed extremes, back to back
    drive(1, 12'h800, 12'h800, 1, 0, 0); tick();
    drive(1, 12'hFFF, 12'h001, 1, 0, 0); tick();
    idle(); tick();
    expect_out("smin_sq", 1, 4194304, 0);
    tick();
    expect_out("sneg1", 1, 28'hFFFFFFF, 0);
    tick();

    // Accumulation with an invalid acc_clr beat in the middle
    drive(1, 12'd100, 12'd3, 0, 1, 1); tick();
    drive(0, 12'd0, 12'd0, 0, 1, 1); tick();
    drive(1, 12'd10, 12'd10, 0, 1, 0); tick();
    expect_out("acc0", 1, 300, 0);
    drive(1, 12'd10, 12'd10, 0, 1, 0); tick();
    expect_out("acc_inv", 0, 300, 0);
    idle(); tick();
    expect_out("acc1", 1, 400, 0);
    tick();
    expect_out("acc2", 1, 500, 0);
    repeat (3) tick();

    // Clock enable low for two cycles with two beats in flight
    drive(1, 12'd7, 12'd9, 0, 0, 0); tick();
    drive(1, 12'd5, 12'd6, 0, 0, 0); tick();
    ce = 1'b0; idle(); tick();
    chk("ce_hold1", 64'(out_valid), 64'd0);
    tick();
    chk("ce_hold2", 64'(out_valid), 64'd0);
    ce = 1'b1; tick();
    expect_out("ce_b1", 1, 63, 0);
    tick();
    expect_out("ce_b2", 1, 30, 0);
    tick();
    chk("ce_nodup", 64'(out_valid), 64'd0);

    // Unsigned carry-out after 17 full-scale beats
    for (int i = 0; i < 17; i++) begin
      drive(1, 12'd4095, 12'd4095, 0, 1, (i == 0)); tick();
    end
    idle(); tick();
    expect_out("ucarry16", 1, 268304400, 0);
    tick();
    expect_out("ucarry17", 1, 16637969, 1);
    tick();
    chk("ovf_sticky", 64'(ovf), 64'd1);
    drive(1, 12'd2, 12'd3, 0, 1, 1); tick();
    idle(); tick(); tick();
    expect_out("ovf_clr", 1, 6, 0);

    // Signed overflow after 32 beats of (-2048)^2
    for (int i = 0; i < 32; i++) begin
      drive(1, 12'h800, 12'h800, 1, 1, (i == 0)); tick();
    end
    idle(); tick();
    expect_out("sacc31", 1, 130023424, 0);
    tick();
    expect_out("sacc32", 1, 134217728, 1);
    drive(1, 12'h800, 12'h7FF, 1, 1, 1); tick();
    drive(1, 12'hFFF, 12'h001, 1, 1, 0); tick();
    idle(); tick();
    expect_out("sneg_clr", 1, 264243200, 0);
    tick();
    expect_out("sneg_acc", 1, 264243199, 0);

    // Reset with two beats in flight
    drive(1, 12'd9, 12'd9, 0, 0, 0); tick();
    drive(1, 12'd3, 12'd3, 0, 0, 0); tick();
    idle();
    reset = 1'b1;
    #1;
    expect_out("rst_now", 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_flush", 64'(out_valid), 64'd0);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
